// File: rtl/ray_pixel_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// ray_pixel_scheduler_pkg
// Scene header shared by the pixel scheduler and the ray tracer core.
//
// Contents:
//   - Default screen resolution.
//   - Ray origin (init) and direction (dir) field widths and bit offsets.
//     The tracer uses the same values to unpack init and dir.
//   - Colour width and the BLACK/WHITE colour constants.
//   - Scheduler FSM state encoding.
//   - Helper function that packs a camera origin into the init word.
// ----------------------------------------------------------------------------
package ray_pixel_scheduler_pkg;

    // Default screen geometry
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    // Pixel coordinate widths (enough for 1024 x 512)
    localparam int PX_W = 10;
    localparam int PY_W = 9;

    // Ray origin: {x[9:0], y[8:0], z[8:0]}
    localparam int ORG_X_W    = 10;
    localparam int ORG_Y_W    = 9;
    localparam int ORG_Z_W    = 9;
    localparam int INIT_W     = ORG_X_W + ORG_Y_W + ORG_Z_W;
    localparam int INIT_X_LSB = ORG_Y_W + ORG_Z_W;
    localparam int INIT_Y_LSB = ORG_Z_W;
    localparam int INIT_Z_LSB = 0;

    // Ray direction: {dx[9:0], dy[9:0], dz[10:0]}, all signed
    localparam int DX_W       = 10;
    localparam int DY_W       = 10;
    localparam int DZ_W       = 11;
    localparam int DIR_W      = DX_W + DY_W + DZ_W;
    localparam int DIR_DX_LSB = DY_W + DZ_W;
    localparam int DIR_DY_LSB = DZ_W;
    localparam int DIR_DZ_LSB = 0;

    // Intermediate precision for the dx/dy subtraction
    localparam int CALC_W = 11;

    // Colour
    localparam int                 COLOR_W = 12;
    localparam logic [COLOR_W-1:0] BLACK   = 12'h000;
    localparam logic [COLOR_W-1:0] WHITE   = 12'hFFF;

    // Frame-buffer address and counter widths
    localparam int ADDR_W = 19;
    localparam int CNT_W  = 16;
    localparam int TCNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_ADVANCE
    } state_t;

    function automatic logic [INIT_W-1:0] pack_init(
        input logic [ORG_X_W-1:0] x,
        input logic [ORG_Y_W-1:0] y,
        input logic [ORG_Z_W-1:0] z
    );
        logic [INIT_W-1:0] v;
        v = '0;
        v[INIT_X_LSB +: ORG_X_W] = x;
        v[INIT_Y_LSB +: ORG_Y_W] = y;
        v[INIT_Z_LSB +: ORG_Z_W] = z;
        return v;
    endfunction

endpackage

// File: rtl/ray_pixel_scheduler_dir_gen.sv
// ----------------------------------------------------------------------------
// ray_pixel_scheduler_dir_gen
// Combinational mapping from a screen pixel (px, py) to the primary ray
// direction. The screen centre maps to dx=0, dy=0; +dy points up, so the
// top line gets the largest dy.
//
// Ports:
//   i_px   in  PX_W   pixel column
//   i_py   in  PY_W   pixel row
//   o_dir  out DIR_W  {dx, dy, dz}, each field signed
// ----------------------------------------------------------------------------
module ray_pixel_scheduler_dir_gen
    import ray_pixel_scheduler_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int FOCAL = 512
) (
    input  logic [PX_W-1:0]  i_px,
    input  logic [PY_W-1:0]  i_py,
    output logic [DIR_W-1:0] o_dir
);

    localparam logic signed [CALC_W-1:0] HALF_H = CALC_W'(H_RES / 2);
    localparam logic signed [CALC_W-1:0] TOP_Y  = CALC_W'(V_RES / 2 - 1);

    logic signed [CALC_W-1:0] w_dx_full;
    logic signed [CALC_W-1:0] w_dy_full;

    // The coordinates are zero-extended into the 11-bit signed domain. The
    // 10-bit truncation that follows is lossless for the supported screen
    // range (dx -320..319, dy -240..239).
    assign w_dx_full = $signed({1'b0, i_px}) - HALF_H;
    assign w_dy_full = TOP_Y - $signed({2'b00, i_py});

    always_comb begin
        o_dir = '0;
        o_dir[DIR_DX_LSB +: DX_W] = w_dx_full[DX_W-1:0];
        o_dir[DIR_DY_LSB +: DY_W] = w_dy_full[DY_W-1:0];
        o_dir[DIR_DZ_LSB +: DZ_W] = DZ_W'(FOCAL);
    end

endmodule

// File: rtl/ray_pixel_scheduler.sv
// ----------------------------------------------------------------------------
// ray_pixel_scheduler
// Frame scheduler wrapped around the ray tracer core. It scans the screen in
// raster order and issues one primary ray per pixel. It waits for the tracer
// to settle and report completion, then writes the returned colour to the
// frame buffer at the pixel's linear address. One frame runs per start pulse.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   begins a frame when idle (ignored otherwise)
//   init         out  28  ray origin {x, y, z} from the camera parameters
//   dir          out  31  ray direction {dx, dy, dz}, signed fields
//   ray_valid    out  1   init/dir are stable and under trace
//   trace_done   in   1   tracer result ready (level)
//   trace_color  in   12  tracer colour
//   fb_we        out  1   frame-buffer write strobe, one cycle per pixel
//   fb_addr      out  19  linear pixel address py*H_RES+px
//   fb_data      out  12  pixel colour
//   busy         out  1   frame in progress
//   frame_done   out  1   one-cycle pulse after the last pixel write
//   timeout_cnt  out  16  pixels forced black this frame (saturating)
// ----------------------------------------------------------------------------
module ray_pixel_scheduler
    import ray_pixel_scheduler_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int FOCAL   = 512,
    parameter int CAM_X   = 0,
    parameter int CAM_Y   = 0,
    parameter int CAM_Z   = 0,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [INIT_W-1:0]   init,
    output logic [DIR_W-1:0]    dir,
    output logic                ray_valid,
    input  logic                trace_done,
    input  logic [COLOR_W-1:0]  trace_color,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOR_W-1:0]  fb_data,
    output logic                busy,
    output logic                frame_done,
    output logic [TCNT_W-1:0]   timeout_cnt
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PX_W-1:0]  PX_LAST      = PX_W'(H_RES - 1);
    localparam logic [PY_W-1:0]  PY_LAST      = PY_W'(V_RES - 1);

    state_t               r_state;
    logic [PX_W-1:0]      r_px;
    logic [PY_W-1:0]      r_py;
    logic [CNT_W-1:0]     r_cnt;
    logic [DIR_W-1:0]     r_dir;
    logic                 r_ray_valid;
    logic                 r_fb_we;
    logic [ADDR_W-1:0]    r_fb_addr;
    logic [COLOR_W-1:0]   r_fb_data;
    logic                 r_busy;
    logic                 r_frame_done;
    logic [TCNT_W-1:0]    r_timeout_cnt;

    logic [DIR_W-1:0]     w_dir;
    logic                 w_last_px;
    logic                 w_last_pix;
    logic                 w_accept;
    logic                 w_expired;

    ray_pixel_scheduler_dir_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .FOCAL (FOCAL)
    ) u_dir_gen (
        .i_px  (r_px),
        .i_py  (r_py),
        .o_dir (w_dir)
    );

    assign w_last_px  = (r_px == PX_LAST);
    assign w_last_pix = w_last_px && (r_py == PY_LAST);

    // The tracer output is combinational on init/dir. A trace_done seen
    // before the settle window has elapsed can belong to the previous ray,
    // so it is not trusted.
    assign w_accept  = trace_done && (r_cnt >= SETTLE_LAST);
    assign w_expired = !w_accept && (r_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_px          <= '0;
            r_py          <= '0;
            r_cnt         <= '0;
            r_dir         <= '0;
            r_ray_valid   <= 1'b0;
            r_fb_we       <= 1'b0;
            r_fb_addr     <= '0;
            r_fb_data     <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_cnt <= '0;
        end else begin
            // Strobes default low and are raised only for the single cycle
            // they belong to.
            r_fb_we      <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state       <= ST_ISSUE;
                        r_busy        <= 1'b1;
                        r_px          <= '0;
                        r_py          <= '0;
                        r_fb_addr     <= '0;
                        r_timeout_cnt <= '0;
                    end
                end

                ST_ISSUE: begin
                    r_dir       <= w_dir;
                    r_ray_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (w_accept) begin
                        r_fb_data   <= trace_color;
                        r_fb_we     <= 1'b1;
                        r_ray_valid <= 1'b0;
                        r_state     <= ST_WRITE;
                    end else if (w_expired) begin
                        r_fb_data   <= BLACK;
                        r_fb_we     <= 1'b1;
                        r_ray_valid <= 1'b0;
                        if (r_timeout_cnt != '1) begin
                            r_timeout_cnt <= r_timeout_cnt + TCNT_W'(1);
                        end
                        r_state     <= ST_WRITE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_WRITE: begin
                    // frame_done and the falling busy are registered here so
                    // they are visible during the ADVANCE cycle that follows
                    // the last write.
                    if (w_last_pix) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                    r_state <= ST_ADVANCE;
                end

                ST_ADVANCE: begin
                    if (w_last_pix) begin
                        r_px      <= '0;
                        r_py      <= '0;
                        r_fb_addr <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        if (w_last_px) begin
                            r_px <= '0;
                            r_py <= r_py + PY_W'(1);
                        end else begin
                            r_px <= r_px + PX_W'(1);
                        end
                        // Raster order makes the linear address a plain
                        // increment across line boundaries.
                        r_fb_addr <= r_fb_addr + ADDR_W'(1);
                        r_state   <= ST_ISSUE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign init        = pack_init(ORG_X_W'(CAM_X), ORG_Y_W'(CAM_Y), ORG_Z_W'(CAM_Z));
    assign dir         = r_dir;
    assign ray_valid   = r_ray_valid;
    assign fb_we       = r_fb_we;
    assign fb_addr     = r_fb_addr;
    assign fb_data     = r_fb_data;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_ray_pixel_scheduler.sv
module tb_ray_pixel_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        trace_done;
    logic [11:0] trace_color;

    // Full-resolution instance (default parameters)
    logic [27:0] b_init;
    logic [30:0] b_dir;
    logic        b_ray_valid;
    logic        b_fb_we;
    logic [18:0] b_fb_addr;
    logic [11:0] b_fb_data;
    logic        b_busy;
    logic        b_frame_done;
    logic [15:0] b_timeout_cnt;

    // Small-screen instance: 4x2, TIMEOUT=10, non-zero camera
    logic [27:0] s_init;
    logic [30:0] s_dir;
    logic        s_ray_valid;
    logic        s_fb_we;
    logic [18:0] s_fb_addr;
    logic [11:0] s_fb_data;
    logic        s_busy;
    logic        s_frame_done;
    logic [15:0] s_timeout_cnt;

    int total;
    int bad;

    ray_pixel_scheduler dut_big (
        .clk(clk), .rst_n(rst_n), .start(start),
        .init(b_init), .dir(b_dir), .ray_valid(b_ray_valid),
        .trace_done(trace_done), .trace_color(trace_color),
        .fb_we(b_fb_we), .fb_addr(b_fb_addr), .fb_data(b_fb_data),
        .busy(b_busy), .frame_done(b_frame_done), .timeout_cnt(b_timeout_cnt)
    );

    ray_pixel_scheduler #(
        .H_RES(4), .V_RES(2), .FOCAL(512),
        .CAM_X(5), .CAM_Y(3), .CAM_Z(7),
        .SETTLE(2), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .init(s_init), .dir(s_dir), .ray_valid(s_ray_valid),
        .trace_done(trace_done), .trace_color(trace_color),
        .fb_we(s_fb_we), .fb_addr(s_fb_addr), .fb_data(s_fb_data),
        .busy(s_busy), .frame_done(s_frame_done), .timeout_cnt(s_timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        trace_done = 1'b0;
        trace_color = 12'h000;
        step();
        step();
        total++;
        if ({s_ray_valid, s_fb_we, s_busy, s_frame_done} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0000", {s_ray_valid, s_fb_we, s_busy, s_frame_done});
        end
        total++;
        if ({s_dir, s_fb_addr, s_fb_data, s_timeout_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_data: dir=%h addr=%h data=%h tcnt=%h want 0", s_dir, s_fb_addr, s_fb_data, s_timeout_cnt);
        end
        total++;
        if (s_init !== {10'd5, 9'd3, 9'd7}) begin
            bad++;
            $display("FAIL reset_init_small: got %h want %h", s_init, {10'd5, 9'd3, 9'd7});
        end
        total++;
        if ({b_init, b_dir, b_ray_valid, b_fb_we, b_fb_addr, b_fb_data, b_busy, b_frame_done, b_timeout_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_big: init=%h dir=%h addr=%h busy=%b", b_init, b_dir, b_fb_addr, b_busy);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Default 640x480 geometry: first ray and write timing
    task automatic test_first_pixel;
        logic early_we;
        trace_done = 1'b1;
        trace_color = 12'hFFF;
        early_we = 1'b0;
        pulse_start();                         // cycle 1: ISSUE
        early_we |= b_fb_we;
        step();                                // cycle 2: WAIT
        early_we |= b_fb_we;
        total++;
        if (b_ray_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_ray_valid: got %b want 1", b_ray_valid);
        end
        total++;
        if (b_dir !== {10'(-320), 10'd239, 11'd512}) begin
            bad++;
            $display("FAIL first_dir: got %h want %h", b_dir, {10'(-320), 10'd239, 11'd512});
        end
        step();                                // cycle 3: WAIT
        early_we |= b_fb_we;
        step();                                // cycle 4: WRITE
        total++;
        if (early_we !== 1'b0) begin
            bad++;
            $display("FAIL first_early_we: got %b want 0", early_we);
        end
        total++;
        if ({b_fb_we, b_ray_valid, b_fb_addr, b_fb_data} !== {1'b1, 1'b0, 19'd0, 12'hFFF}) begin
            bad++;
            $display("FAIL first_write: we=%b rv=%b addr=%0d data=%h want we=1 rv=0 addr=0 data=FFF", b_fb_we, b_ray_valid, b_fb_addr, b_fb_data);
        end
        early_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            early_we |= b_fb_we;
        end
        step();                                // cycle 9: second WRITE
        total++;
        if ({early_we, b_fb_we, b_fb_addr} !== {1'b0, 1'b1, 19'd1}) begin
            bad++;
            $display("FAIL second_write_spacing: between=%b we=%b addr=%0d want 0 1 1", early_we, b_fb_we, b_fb_addr);
        end
        total++;
        if (b_dir !== {10'(-319), 10'd239, 11'd512}) begin
            bad++;
            $display("FAIL second_dir: got %h want %h", b_dir, {10'(-319), 10'd239, 11'd512});
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_frame;
        int nw, nfd, cyc, last_cyc, px, py;
        trace_done = 1'b1;
        trace_color = 12'h123;
        nw = 0;
        nfd = 0;
        last_cyc = -100;
        pulse_start();
        cyc = 1;
        while (cyc < 80) begin
            if (s_fb_we) begin
                px = nw % 4;
                py = nw / 4;
                total++;
                if ({s_fb_addr, s_fb_data, s_busy} !== {19'(nw), 12'h123, 1'b1}) begin
                    bad++;
                    $display("FAIL frame_write%0d: addr=%0d data=%h busy=%b want addr=%0d data=123 busy=1", nw, s_fb_addr, s_fb_data, s_busy, nw);
                end
                total++;
                if (s_dir !== {10'(px - 2), 10'(0 - py), 11'd512}) begin
                    bad++;
                    $display("FAIL frame_dir%0d: got %h want %h", nw, s_dir, {10'(px - 2), 10'(0 - py), 11'd512});
                end
                total++;
                if ((nw == 0 && cyc != 4) || (nw > 0 && cyc - last_cyc != 5)) begin
                    bad++;
                    $display("FAIL frame_timing%0d: cycle=%0d prev=%0d want first=4 spacing=5", nw, cyc, last_cyc);
                end
                last_cyc = cyc;
                nw++;
            end
            if (s_frame_done) begin
                nfd++;
                total++;
                if (cyc != last_cyc + 1 || s_busy !== 1'b0 || nw != 8) begin
                    bad++;
                    $display("FAIL frame_done_pos: cycle=%0d lastwe=%0d busy=%b writes=%0d want cycle=lastwe+1 busy=0 writes=8", cyc, last_cyc, s_busy, nw);
                end
            end
            step();
            cyc++;
        end
        total++;
        if (nw != 8 || nfd != 1 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_totals: writes=%0d done=%0d busy=%b want 8 1 0", nw, nfd, s_busy);
        end
    endtask

    task automatic finish_frame(input string name);
        int n;
        trace_done = 1'b1;
        n = 0;
        while (!s_frame_done && n < 200) begin
            step();
            n++;
        end
        total++;
        if (s_frame_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_frame_end: frame_done=%b want 1 within 200 cycles", name, s_frame_done);
        end
        step();
        step();
    endtask

    task automatic test_early_done;
        logic early_we;
        trace_done = 1'b0;
        trace_color = 12'hF00;
        pulse_start();                         // cycle 1: ISSUE
        step();                                // cycle 2: WAIT cnt 0
        trace_done = 1'b1;
        step();                                // cycle 3
        trace_done = 1'b0;
        trace_color = 12'h0F0;
        early_we = s_fb_we;
        step();                                // cycle 4
        early_we |= s_fb_we;
        step();                                // cycle 5: WAIT cnt 3
        early_we |= s_fb_we;
        trace_done = 1'b1;
        step();                                // cycle 6: WRITE
        total++;
        if (early_we !== 1'b0) begin
            bad++;
            $display("FAIL early_pulse_accepted: we seen=%b want 0", early_we);
        end
        total++;
        if ({s_fb_we, s_fb_addr, s_fb_data} !== {1'b1, 19'd0, 12'h0F0}) begin
            bad++;
            $display("FAIL late_accept: we=%b addr=%0d data=%h want 1 0 0F0", s_fb_we, s_fb_addr, s_fb_data);
        end
        finish_frame("early");
    endtask

    task automatic test_timeout;
        logic early_we;
        logic rv_held;
        trace_done = 1'b0;
        trace_color = 12'hABC;
        early_we = 1'b0;
        rv_held = 1'b1;
        pulse_start();                         // cycle 1: ISSUE
        early_we |= s_fb_we;
        for (int c = 2; c <= 11; c++) begin    // WAIT cycles 2..11
            step();
            early_we |= s_fb_we;
            rv_held &= s_ray_valid;
        end
        step();                                // cycle 12: WRITE
        total++;
        if (early_we !== 1'b0 || rv_held !== 1'b1) begin
            bad++;
            $display("FAIL timeout_wait: early_we=%b ray_valid_held=%b want 0 1", early_we, rv_held);
        end
        total++;
        if ({s_fb_we, s_fb_addr, s_fb_data, s_timeout_cnt} !== {1'b1, 19'd0, 12'h000, 16'd1}) begin
            bad++;
            $display("FAIL timeout_write: we=%b addr=%0d data=%h tcnt=%0d want 1 0 000 1", s_fb_we, s_fb_addr, s_fb_data, s_timeout_cnt);
        end
        trace_done = 1'b1;
        trace_color = 12'h0AB;
        for (int c = 13; c <= 17; c++) step();  // pixel 1 WRITE at cycle 17
        total++;
        if ({s_fb_we, s_fb_addr, s_fb_data, s_timeout_cnt} !== {1'b1, 19'd1, 12'h0AB, 16'd1}) begin
            bad++;
            $display("FAIL timeout_continue: we=%b addr=%0d data=%h tcnt=%0d want 1 1 0AB 1", s_fb_we, s_fb_addr, s_fb_data, s_timeout_cnt);
        end
        finish_frame("timeout");
    endtask

    task automatic test_start_ignored;
        int nw, nfd, cyc, after_we;
        logic seq_err;
        trace_done = 1'b1;
        trace_color = 12'h555;
        nw = 0;
        nfd = 0;
        seq_err = 1'b0;
        pulse_start();
        total++;
        if (s_timeout_cnt !== 16'd0) begin
            bad++;
            $display("FAIL tcnt_clear: got %0d want 0", s_timeout_cnt);
        end
        cyc = 1;
        while (cyc < 60) begin
            start = 1'b0;
            if (s_fb_we) begin
                if (s_fb_addr !== 19'(nw)) seq_err = 1'b1;
                nw++;
                if (nw == 3) start = 1'b1;       // lands in pixel 3
            end
            if (s_frame_done) begin
                nfd++;
                start = 1'b1;                    // coincident with frame_done
            end
            step();
            cyc++;
        end
        start = 1'b0;
        total++;
        if (nw != 8 || nfd != 1 || seq_err !== 1'b0) begin
            bad++;
            $display("FAIL no_restart: writes=%0d done=%0d seq_err=%b want 8 1 0", nw, nfd, seq_err);
        end
        after_we = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_fb_we || s_busy) after_we++;
        end
        total++;
        if (after_we != 0) begin
            bad++;
            $display("FAIL stays_idle: active cycles=%0d want 0", after_we);
        end
    endtask

    task automatic test_reset_mid_wait;
        int stray;
        trace_done = 1'b1;
        trace_color = 12'h3C3;
        pulse_start();                         // cycle 1
        for (int c = 2; c <= 9; c++) step();   // pixel 1 WRITE at cycle 9
        trace_done = 1'b0;
        for (int c = 10; c <= 13; c++) step(); // cycle 13: WAIT of pixel 2
        total++;
        if ({s_ray_valid, s_busy, s_fb_addr} !== {1'b1, 1'b1, 19'd2}) begin
            bad++;
            $display("FAIL pre_reset_state: rv=%b busy=%b addr=%0d want 1 1 2", s_ray_valid, s_busy, s_fb_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({s_dir, s_ray_valid, s_fb_we, s_fb_addr, s_fb_data, s_busy, s_frame_done, s_timeout_cnt} !== '0) begin
            bad++;
            $display("FAIL async_reset: dir=%h rv=%b addr=%0d data=%h busy=%b want all 0", s_dir, s_ray_valid, s_fb_addr, s_fb_data, s_busy);
        end
        trace_done = 1'b1;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (s_fb_we || s_frame_done) stray++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_fb_we || s_frame_done) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_no_write: strobes=%0d want 0", stray);
        end
        pulse_start();                         // cycle 1
        step();
        step();
        step();                                // cycle 4: WRITE
        total++;
        if ({s_fb_we, s_fb_addr, s_fb_data} !== {1'b1, 19'd0, 12'h3C3}) begin
            bad++;
            $display("FAIL restart_addr: we=%b addr=%0d data=%h want 1 0 3C3", s_fb_we, s_fb_addr, s_fb_data);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        trace_done = 1'b0;
        trace_color = 12'h000;
        test_reset();
        test_first_pixel();
        test_full_frame();
        test_early_done();
        test_timeout();
        test_start_ignored();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ray_pixel_scheduler.md
Name: ray_pixel_scheduler

Overview:
Upstream/downstream wrapper stage around the ray tracer core. Scans the screen in raster order and generates one primary ray (init, dir) per pixel. It waits for the tracer to settle and report completion, then writes the returned 12-bit colour into the frame buffer at the pixel's linear address. Runs one full frame per start pulse.

Parameters:
H_RES, 640, horizontal pixels per line
V_RES, 480, lines per frame
FOCAL, 512, dz component of every ray (positive, fits 11-bit signed)
CAM_X, 0, camera origin x (10 bits)
CAM_Y, 0, camera origin y (9 bits)
CAM_Z, 0, camera origin z (9 bits)
SETTLE, 2, minimum cycles the ray is held before trace_done is accepted (>=1)
TIMEOUT, 255, cycles in WAIT before the pixel is forced to black

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
init  out  28  ray origin {x[9:0], y[8:0], z[8:0]} = {CAM_X, CAM_Y, CAM_Z}
dir  out  31  ray direction {dx[9:0] signed, dy[9:0] signed, dz[10:0] signed}
ray_valid  out  1  init/dir are stable and under trace
trace_done  in  1  tracer result ready (level)
trace_color  in  12  tracer colour output
fb_we  out  1  frame-buffer write strobe, one cycle per pixel
fb_addr  out  19  linear address py*H_RES+px
fb_data  out  12  pixel colour
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last pixel write
timeout_cnt  out  16  pixels forced black in the current frame (saturating)

Behaviour:
- Reset (async, rst_n=0): state IDLE, px=py=0, all outputs 0, init driven from the camera parameters, dir=0, timeout_cnt=0.
- FSM states: IDLE, ISSUE, WAIT, WRITE, ADVANCE.
- IDLE: start=1 -> ISSUE; busy=1; px=py=0; fb_addr=0; timeout_cnt cleared.
- ISSUE (1 cycle): register dir with dx=px-H_RES/2, dy=V_RES/2-1-py, dz=FOCAL. Set ray_valid=1, load the settle/timeout counter with 0, go to WAIT.
- WAIT: the counter increments each cycle. dir/init are held constant.
  - trace_done=1 and counter>=SETTLE-1: latch trace_color into fb_data, go to WRITE.
  - Counter reaches TIMEOUT with trace_done still 0: fb_data=12'h000, timeout_cnt++ (saturates at FFFF), go to WRITE.
  - trace_done high before the settle period completes is ignored, because the combinational tracer output is stale.
- WRITE (1 cycle): fb_we=1 and ray_valid=0. fb_addr equals the current pixel address. Go to ADVANCE.
- ADVANCE (1 cycle):
  - px==H_RES-1: px=0, py++.
  - Otherwise px++.
  - fb_addr increments by 1 (maintained incrementally; no multiplier).
  - px==H_RES-1 and py==V_RES-1: frame_done=1 for this cycle, busy=0, go to IDLE with px=py=0.
  - Otherwise go to ISSUE.
- Nominal latency per pixel: 1 (ISSUE) + SETTLE (WAIT) + 1 (WRITE) + 1 (ADVANCE) cycles. Default is 5 cycles per pixel and 1,536,000 cycles per frame.
- start while busy: ignored, no restart.
- start in the same cycle as frame_done: ignored; a new start is required.
- Width rules:
  - dx and dy are computed in 11-bit signed arithmetic, then truncated to 10 bits. Range: dx -320..319, dy -240..239.
  - dz is sign-extended to 11 bits.
- Reset mid-frame: immediate abort. No further fb_we, and no frame_done.

Decomposition:
- Shared package (scene header): H_RES/V_RES defaults, the ray field widths and bit-slice offsets for init/dir, and BLACK/WHITE colour constants. These are the same values the tracer uses to unpack init/dir.
- Natural sub-module: ray_dir_gen, a combinational mapping from (px, py) to dir using the package widths.

Test Plan:
1. Reset, then start with trace_done tied 1 and trace_color=12'hFFF, SETTLE=2 -> first fb_we at cycle 4 after start with fb_addr=0 and dir={-320, 239, 512}. Writes are spaced 5 cycles apart.
2. Full frame with H_RES=4, V_RES=2 -> 8 writes at addrs 0..7; frame_done pulses once, 1 cycle after write 7; busy falls with it.
3. trace_done pulses high in cycle 0 of WAIT only, then high from cycle 3 with colour 12'h0F0 -> the early pulse is ignored; fb_data=12'h0F0 is written at the later acceptance.
4. trace_done held 0, TIMEOUT=10 -> fb_data=000 written after 10 WAIT cycles, timeout_cnt=1, and the scan continues to the next pixel.
5. start pulsed during pixel 3 of a frame, and again coincident with frame_done -> no restart; exactly H_RES*V_RES writes occur; IDLE remains until a fresh start.
6. rst_n asserted low mid-WAIT -> all outputs 0 asynchronously. After release, start begins again at fb_addr=0.
